// File: rtl/lab3_dg_keypad_model_if.sv
// Command port of the keypad model: one-key press/release requests and their completion status.
// The bench or self-test logic drives the master side; the keypad model is the slave.
interface lab3_dg_keypad_model_if;
  logic       key_req;
  logic       key_press;
  logic [3:0] key_code;
  logic       key_ack;
  logic       key_err;
  logic       key_held;
  logic       busy;

  modport master (
    output key_req,
    output key_press,
    output key_code,
    input  key_ack,
    input  key_err,
    input  key_held,
    input  busy
  );

  modport slave (
    input  key_req,
    input  key_press,
    input  key_code,
    output key_ack,
    output key_err,
    output key_held,
    output busy
  );
endinterface

// File: rtl/lab3_dg_keypad_model.sv
// Responder model of a 4x4 active-low matrix keypad with contact bounce on press and release.
// One key at a time is pressed and released through the command interface.
module lab3_dg_keypad_model #(
  parameter int unsigned BOUNCE_LEN  = 8,
  parameter int unsigned CHATTER_DIV = 2
) (
  input  logic                         int_osc,
  input  logic                         reset,
  input  logic [3:0]                   cols,
  output logic [3:0]                   rows,
  lab3_dg_keypad_model_if.slave        kp
);

  localparam logic [7:0] KLast   = 8'(BOUNCE_LEN - 1);
  localparam logic [7:0] DivLast = 8'(CHATTER_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBounceIn,
    StHeld,
    StBounceOut
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] k_q, k_d;
  logic [7:0] div_q, div_d;
  logic       phase_q, phase_d;   // 1 = contact closed during the current chatter half-period
  logic [3:0] key_q, key_d;
  logic [3:0] rows_q, rows_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       bouncing;
  logic       contact;

  assign bouncing = (state_q == StBounceIn) || (state_q == StBounceOut);
  assign contact  = (state_q == StHeld) || (bouncing && phase_q);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    div_d   = div_q;
    phase_d = phase_q;
    key_d   = key_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (kp.key_req) begin
          if (kp.key_press) begin
            key_d   = kp.key_code;
            k_d     = 8'd0;
            div_d   = 8'd0;
            phase_d = 1'b1;
            state_d = StBounceIn;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      StBounceIn, StBounceOut: begin
        if (k_q == KLast) begin
          state_d = (state_q == StBounceIn) ? StHeld : StIdle;
          ack_d   = 1'b1;
        end else begin
          k_d = k_q + 8'd1;
          // Half-period counter gives floor(k/CHATTER_DIV) parity without a divider.
          if (div_q == DivLast) begin
            div_d   = 8'd0;
            phase_d = ~phase_q;
          end else begin
            div_d = div_q + 8'd1;
          end
        end
      end
      StHeld: begin
        if (kp.key_req) begin
          if (!kp.key_press) begin
            k_d     = 8'd0;
            div_d   = 8'd0;
            phase_d = 1'b1;
            state_d = StBounceOut;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rows_d = 4'b1111;
    if (contact && !cols[key_q[1:0]]) begin
      rows_d[key_q[3:2]] = 1'b0;
    end
  end

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      k_q     <= 8'd0;
      div_q   <= 8'd0;
      phase_q <= 1'b0;
      key_q   <= 4'b0000;
      rows_q  <= 4'b1111;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      key_q   <= key_d;
      rows_q  <= rows_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign rows        = rows_q;
  assign kp.key_ack  = ack_q;
  assign kp.key_err  = err_q;
  assign kp.key_held = (state_q == StHeld);
  assign kp.busy     = bouncing;

endmodule
